// File: rtl/ahb_split_slave.sv
// AHB slave with a zero-wait RAM region, a split region aliasing the same RAM,
// and an error region. Split masters are released through a one-hot HSPLIT pulse.
module ahb_split_slave #(
  parameter int SPLIT_DELAY = 4,
  parameter int MEM_WORDS   = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] ahbm_HADDR,
  input  logic [1:0]  ahbm_HTRANS,
  input  logic        ahbm_ahbs_HWRITE,
  input  logic [2:0]  ahbm_ahbs_HSIZE,
  input  logic [2:0]  ahbm_HBURST,
  input  logic [31:0] ahbm_ahbs_HWDATA,
  input  logic [3:0]  arb_ahbs_HMASTER,
  input  logic        arb_ahbs_HMASTLOCK,
  output logic        ahbs_HREADY,
  output logic [1:0]  ahbs_HRESP,
  output logic [31:0] ahbs_ahbm_HRDATA,
  output logic [15:0] ahbs_arb_HSPLIT,
  output logic [1:0]  dbg_state
);

  localparam int IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_W    = (SPLIT_DELAY > 1) ? $clog2(SPLIT_DELAY + 1) : 1;
  localparam int REL_LOAD = (SPLIT_DELAY > 0) ? SPLIT_DELAY - 1 : 0;

  localparam logic [1:0] R_OKAY  = 2'b00;
  localparam logic [1:0] R_ERROR = 2'b01;
  localparam logic [1:0] R_RETRY = 2'b10;
  localparam logic [1:0] R_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESP1 = 2'd1,
    S_RESP2 = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    K_NONE, K_OK, K_LOCK, K_ERR, K_RETRY, K_SPLIT
  } kind_t;

  state_t state_q, state_d;
  kind_t  kind;

  logic [1:0]       resp_q, resp_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             dp_valid_q, dp_valid_d;
  logic             dp_write_q, dp_write_d;
  logic [IDX_W-1:0] dp_idx_q, dp_idx_d;
  logic [1:0]       dp_lo_q, dp_lo_d;
  logic [1:0]       dp_size_q, dp_size_d;
  logic [31:0]      hold_q, hold_d;
  logic             split_pend_q, split_pend_d;
  logic             split_rel_q, split_rel_d;
  logic             split_run_q, split_run_d;
  logic [CNT_W-1:0] split_cnt_q, split_cnt_d;
  logic [3:0]       split_mst_q, split_mst_d;
  logic [31:0]      mem_q [MEM_WORDS];
  logic [31:0]      mem_d [MEM_WORDS];

  logic             acc_start, bad_size, is_err_rgn, is_split_rgn, split_owner;
  logic [IDX_W-1:0] acc_idx;
  logic             dp_done, rd_phase, wr_en;
  logic [3:0]       lane_en;
  logic             cg_en_lat, ram_clk;
  logic             unused_ok;

  assign unused_ok = ^{ahbm_HBURST, ahbm_HADDR[31:8], ahbm_HTRANS[0]};

  // Handshake: an address phase is taken only when HREADY is high in the same
  // cycle; the data phase then completes in the first later cycle with HREADY high.
  assign acc_start    = ahbs_HREADY & HSEL & ahbm_HTRANS[1];
  assign is_err_rgn   = ahbm_HADDR[7];
  assign is_split_rgn = (ahbm_HADDR[7:6] == 2'b01);
  assign split_owner  = split_pend_q & split_rel_q & (arb_ahbs_HMASTER == split_mst_q);
  assign acc_idx      = IDX_W'({28'd0, ahbm_HADDR[5:2]} % MEM_WORDS);

  always_comb begin
    bad_size = 1'b0;
    case (ahbm_ahbs_HSIZE)
      3'd0:    bad_size = 1'b0;
      3'd1:    bad_size = ahbm_HADDR[0];
      3'd2:    bad_size = |ahbm_HADDR[1:0];
      default: bad_size = 1'b1;
    endcase
  end

  always_comb begin
    kind = K_NONE;
    if (acc_start) begin
      if (is_err_rgn || bad_size)  kind = K_ERR;
      else if (!is_split_rgn)      kind = K_OK;
      else if (arb_ahbs_HMASTLOCK) kind = K_LOCK;
      else if (!split_pend_q)      kind = K_SPLIT;
      else if (split_owner)        kind = K_OK;
      else                         kind = K_RETRY;
    end
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state: IDLE and RESP2 both present HREADY high, so both accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESP1: state_d = S_RESP2;
      S_WAIT:  if (wait_cnt_q <= CNT_W'(1)) state_d = S_IDLE;
      default: begin
        case (kind)
          K_ERR, K_RETRY, K_SPLIT: state_d = S_RESP1;
          K_LOCK:                  state_d = (SPLIT_DELAY > 0) ? S_WAIT : S_IDLE;
          default:                 state_d = S_IDLE;
        endcase
      end
    endcase
  end

  // Outputs from state
  always_comb begin
    ahbs_HREADY = 1'b1;
    ahbs_HRESP  = R_OKAY;
    case (state_q)
      S_RESP1: begin
        ahbs_HREADY = 1'b0;
        ahbs_HRESP  = resp_q;
      end
      S_RESP2: ahbs_HRESP  = resp_q;
      S_WAIT:  ahbs_HREADY = 1'b0;
      default: ;
    endcase
  end

  assign dbg_state = state_q;

  assign dp_done  = dp_valid_q & (state_q == S_IDLE);
  assign rd_phase = dp_done & ~dp_write_q;
  assign wr_en    = dp_done & dp_write_q;

  always_comb begin
    resp_d     = resp_q;
    wait_cnt_d = wait_cnt_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    dp_lo_d    = dp_lo_q;
    dp_size_d  = dp_size_q;
    if (state_q == S_WAIT) wait_cnt_d = wait_cnt_q - CNT_W'(1);
    if (dp_done) dp_valid_d = 1'b0;
    case (kind)
      K_ERR:   resp_d = R_ERROR;
      K_RETRY: resp_d = R_RETRY;
      K_SPLIT: resp_d = R_SPLIT;
      K_OK, K_LOCK: begin
        resp_d     = R_OKAY;
        dp_valid_d = 1'b1;
        dp_write_d = ahbm_ahbs_HWRITE;
        dp_idx_d   = acc_idx;
        dp_lo_d    = ahbm_HADDR[1:0];
        dp_size_d  = ahbm_ahbs_HSIZE[1:0];
        if (kind == K_LOCK) wait_cnt_d = CNT_W'(SPLIT_DELAY);
      end
      default: ;
    endcase
  end

  // The release countdown starts once the SPLIT response has finished.
  always_comb begin
    split_pend_d = split_pend_q;
    split_rel_d  = split_rel_q;
    split_run_d  = split_run_q;
    split_cnt_d  = split_cnt_q;
    split_mst_d  = split_mst_q;
    if (split_run_q) begin
      if (split_cnt_q == '0) begin
        split_run_d = 1'b0;
        split_rel_d = 1'b1;
      end else begin
        split_cnt_d = split_cnt_q - CNT_W'(1);
      end
    end
    if (state_q == S_RESP2 && resp_q == R_SPLIT) begin
      split_run_d = 1'b1;
      split_cnt_d = CNT_W'(REL_LOAD);
    end
    if (kind == K_SPLIT) begin
      split_pend_d = 1'b1;
      split_rel_d  = 1'b0;
      split_mst_d  = arb_ahbs_HMASTER;
    end
    if (kind == K_OK && is_split_rgn) begin
      split_pend_d = 1'b0;
      split_rel_d  = 1'b0;
    end
  end

  assign ahbs_arb_HSPLIT = (split_run_q && split_cnt_q == '0) ? (16'd1 << split_mst_q) : 16'd0;

  assign hold_d           = rd_phase ? mem_q[dp_idx_q] : hold_q;
  assign ahbs_ahbm_HRDATA = hold_d;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      resp_q       <= R_OKAY;
      wait_cnt_q   <= '0;
      dp_valid_q   <= 1'b0;
      dp_write_q   <= 1'b0;
      dp_idx_q     <= '0;
      dp_lo_q      <= '0;
      dp_size_q    <= '0;
      hold_q       <= '0;
      split_pend_q <= 1'b0;
      split_rel_q  <= 1'b0;
      split_run_q  <= 1'b0;
      split_cnt_q  <= '0;
      split_mst_q  <= '0;
    end else begin
      resp_q       <= resp_d;
      wait_cnt_q   <= wait_cnt_d;
      dp_valid_q   <= dp_valid_d;
      dp_write_q   <= dp_write_d;
      dp_idx_q     <= dp_idx_d;
      dp_lo_q      <= dp_lo_d;
      dp_size_q    <= dp_size_d;
      hold_q       <= hold_d;
      split_pend_q <= split_pend_d;
      split_rel_q  <= split_rel_d;
      split_run_q  <= split_run_d;
      split_cnt_q  <= split_cnt_d;
      split_mst_q  <= split_mst_d;
    end
  end

  always_comb begin
    lane_en = 4'b0000;
    case (dp_size_q)
      2'd0:    lane_en = 4'b0001 << dp_lo_q;
      2'd1:    lane_en = dp_lo_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    for (int b = 0; b < 4; b++) begin
      if (lane_en[b]) mem_d[dp_idx_q][8*b +: 8] = ahbm_ahbs_HWDATA[8*b +: 8];
    end
  end

  // Latch holds the enable through the high phase so the gated clock cannot glitch.
  always_latch begin
    if (!HCLK) cg_en_lat <= wr_en;
  end

  assign ram_clk = HCLK & cg_en_lat;

  always_ff @(posedge ram_clk or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_ahb_split_slave.sv
// Directed plus randomized bench for ahb_split_slave, checked against a
// transaction-level model of the RAM and the split/release rules.
module tb_ahb_split_slave;

  localparam int SPLIT_DELAY = 4;
  localparam int MEM_WORDS   = 16;

  localparam logic [1:0] OKAY  = 2'b00;
  localparam logic [1:0] ERROR = 2'b01;
  localparam logic [1:0] RETRY = 2'b10;
  localparam logic [1:0] SPLIT = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] ahbm_HADDR = '0;
  logic [1:0]  ahbm_HTRANS = 2'b00;
  logic        ahbm_ahbs_HWRITE = 1'b0;
  logic [2:0]  ahbm_ahbs_HSIZE = 3'd2;
  logic [2:0]  ahbm_HBURST = 3'd0;
  logic [31:0] ahbm_ahbs_HWDATA = '0;
  logic [3:0]  arb_ahbs_HMASTER = '0;
  logic        arb_ahbs_HMASTLOCK = 1'b0;
  logic        ahbs_HREADY;
  logic [1:0]  ahbs_HRESP;
  logic [31:0] ahbs_ahbm_HRDATA;
  logic [15:0] ahbs_arb_HSPLIT;
  logic [1:0]  dbg_state;

  ahb_split_slave #(.SPLIT_DELAY(SPLIT_DELAY), .MEM_WORDS(MEM_WORDS)) dut (
    .HCLK               (HCLK),
    .HRESETn            (HRESETn),
    .HSEL               (HSEL),
    .ahbm_HADDR         (ahbm_HADDR),
    .ahbm_HTRANS        (ahbm_HTRANS),
    .ahbm_ahbs_HWRITE   (ahbm_ahbs_HWRITE),
    .ahbm_ahbs_HSIZE    (ahbm_ahbs_HSIZE),
    .ahbm_HBURST        (ahbm_HBURST),
    .ahbm_ahbs_HWDATA   (ahbm_ahbs_HWDATA),
    .arb_ahbs_HMASTER   (arb_ahbs_HMASTER),
    .arb_ahbs_HMASTLOCK (arb_ahbs_HMASTLOCK),
    .ahbs_HREADY        (ahbs_HREADY),
    .ahbs_HRESP         (ahbs_HRESP),
    .ahbs_ahbm_HRDATA   (ahbs_ahbm_HRDATA),
    .ahbs_arb_HSPLIT    (ahbs_arb_HSPLIT),
    .dbg_state          (dbg_state)
  );

  // Clock and cycle index
  always #5 HCLK = ~HCLK;
  int cyc = 0;
  always @(posedge HCLK) cyc++;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] mem_m [MEM_WORDS];
  logic        split_pend = 1'b0;
  logic [3:0]  split_mst  = '0;
  int          pulse_cyc  = -1;
  logic [31:0] last_rd    = '0;
  logic        mon_en     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // HSPLIT must be zero except for the single predicted release cycle.
  always @(negedge HCLK) begin
    if (mon_en) begin
      check("hsplit", {16'd0, ahbs_arb_HSPLIT},
            (split_pend && cyc == pulse_cyc) ? (32'd1 << split_mst) : 32'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < MEM_WORDS; i++) mem_m[i] = '0;
    split_pend = 1'b0;
    pulse_cyc  = -1;
    last_rd    = '0;
  endtask

  task automatic async_reset();
    HRESETn     = 1'b0;
    HSEL        = 1'b0;
    ahbm_HTRANS = 2'b00;
    model_clear();
    #1;
    check("rst_hready", {31'd0, ahbs_HREADY}, 32'd1);
    check("rst_hresp", {30'd0, ahbs_HRESP}, {30'd0, OKAY});
    check("rst_hrdata", ahbs_ahbm_HRDATA, 32'd0);
    check("rst_hsplit", {16'd0, ahbs_arb_HSPLIT}, 32'd0);
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  // One complete transfer: called and returns at 1 time unit after a rising edge.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [3:0] mst, input logic lock);
    int          a_cyc, idx, waits, exp_waits;
    logic [1:0]  exp_resp, first_resp, resp;
    logic [31:0] rd;
    logic        bad, do_access, lane;
    a_cyc     = cyc;
    idx       = int'(addr[5:2]) % MEM_WORDS;
    bad       = (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
    exp_resp  = OKAY;
    exp_waits = 0;
    do_access = 1'b0;
    if (addr[7] || bad) begin
      exp_resp = ERROR; exp_waits = 1;
    end else if (addr[7:6] == 2'b00) begin
      do_access = 1'b1;
    end else if (lock) begin
      do_access = 1'b1; exp_waits = SPLIT_DELAY;
    end else if (!split_pend) begin
      exp_resp = SPLIT; exp_waits = 1;
      split_pend = 1'b1; split_mst = mst;
      pulse_cyc = a_cyc + 2 + SPLIT_DELAY;
    end else if (mst == split_mst && a_cyc > pulse_cyc) begin
      do_access = 1'b1; split_pend = 1'b0;
    end else begin
      exp_resp = RETRY; exp_waits = 1;
    end

    HSEL = 1'b1; ahbm_HTRANS = 2'b10; ahbm_HADDR = addr; ahbm_ahbs_HWRITE = wr;
    ahbm_ahbs_HSIZE = size; arb_ahbs_HMASTER = mst; arb_ahbs_HMASTLOCK = lock;
    ahbm_HBURST = 3'($urandom_range(0, 7));
    @(posedge HCLK);
    #1;
    HSEL = 1'b0; ahbm_HTRANS = 2'b00; arb_ahbs_HMASTLOCK = 1'b0;
    ahbm_ahbs_HWDATA = wdata;
    ahbm_HADDR = 32'($urandom);

    waits = 0; first_resp = OKAY;
    for (int i = 0; i < 40; i++) begin
      @(negedge HCLK);
      if (ahbs_HREADY) break;
      if (waits == 0) first_resp = ahbs_HRESP;
      waits++;
    end
    resp = ahbs_HRESP;
    rd   = ahbs_ahbm_HRDATA;
    check("resp", {30'd0, resp}, {30'd0, exp_resp});
    check("waits", waits, exp_waits);
    if (exp_waits > 0) check("resp_first", {30'd0, first_resp}, {30'd0, exp_resp});
    if (do_access && !wr) begin
      check("rdata", rd, mem_m[idx]);
      last_rd = mem_m[idx];
    end
    if (do_access && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (size == 3'd0)      lane = (b == int'(addr[1:0]));
        else if (size == 3'd1) lane = ((b / 2) == int'(addr[1]));
        else                   lane = 1'b1;
        if (lane) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    @(posedge HCLK);
    #1;
    @(negedge HCLK);
    check("idle_hready", {31'd0, ahbs_HREADY}, 32'd1);
    check("hrdata_hold", ahbs_ahbm_HRDATA, last_rd);
    @(posedge HCLK);
    #1;
  endtask

  task automatic drain_split();
    int guard;
    guard = 0;
    while (split_pend && cyc <= pulse_cyc && guard < 50) begin
      idle(1);
      guard++;
    end
    if (split_pend) xfer(32'h40, 1'b0, 3'd2, 32'd0, split_mst, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    logic [3:0]  m;
    model_clear();
    #2;
    mon_en = 1'b1;
    async_reset();

    // Basic RAM accesses
    xfer(32'h00, 1'b0, 3'd2, 32'd0, 4'd0, 1'b0);
    xfer(32'h04, 1'b1, 3'd2, 32'hDEADBEEF, 4'd0, 1'b0);
    xfer(32'h04, 1'b0, 3'd2, 32'd0, 4'd0, 1'b0);
    check("req035_rdata", last_rd, 32'hDEADBEEF);
    xfer(32'h04, 1'b1, 3'd2, 32'h11223344, 4'd1, 1'b0);
    xfer(32'h07, 1'b1, 3'd0, 32'hAA000000, 4'd1, 1'b0);
    xfer(32'h04, 1'b0, 3'd2, 32'd0, 4'd1, 1'b0);
    check("req036_rdata", last_rd, 32'hAA223344);
    xfer(32'h0A, 1'b1, 3'd1, 32'h5A5A0000, 4'd2, 1'b0);
    xfer(32'h08, 1'b0, 3'd2, 32'd0, 4'd2, 1'b0);
    xfer(32'h0D, 1'b0, 3'd1, 32'd0, 4'd2, 1'b0);
    xfer(32'h02, 1'b1, 3'd3, 32'hFFFFFFFF, 4'd2, 1'b0);
    xfer(32'h00, 1'b0, 3'd2, 32'd0, 4'd2, 1'b0);

    // Split sequence for master 3
    xfer(32'h40, 1'b0, 3'd2, 32'd0, 4'd3, 1'b0);
    xfer(32'h40, 1'b0, 3'd2, 32'd0, 4'd3, 1'b0);
    xfer(32'h44, 1'b0, 3'd2, 32'd0, 4'd5, 1'b0);
    xfer(32'h80, 1'b0, 3'd2, 32'd0, 4'd5, 1'b0);
    xfer(32'h01, 1'b0, 3'd1, 32'd0, 4'd5, 1'b0);
    xfer(32'h40, 1'b0, 3'd2, 32'd0, 4'd3, 1'b0);
    check("req037_rdata", last_rd, 32'd0);

    // Locked access to the split region
    xfer(32'h40, 1'b0, 3'd2, 32'd0, 4'd1, 1'b1);
    xfer(32'h48, 1'b1, 3'd2, 32'hCAFEF00D, 4'd1, 1'b1);
    xfer(32'h08, 1'b0, 3'd2, 32'd0, 4'd0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 160; t++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      case ($urandom_range(0, 2))
        0:       m = 4'd3;
        1:       m = 4'd5;
        default: m = 4'd6;
      endcase
      xfer(a, 1'($urandom_range(0, 1)), sz, $urandom, m, ($urandom_range(0, 7) == 0));
      idle($urandom_range(0, 3));
    end
    drain_split();

    // Reset while the release countdown is running
    xfer(32'h48, 1'b0, 3'd2, 32'd0, 4'd2, 1'b0);
    #1;
    async_reset();
    idle(10);
    xfer(32'h04, 1'b0, 3'd2, 32'd0, 4'd0, 1'b0);
    xfer(32'h48, 1'b0, 3'd2, 32'd0, 4'd2, 1'b0);
    drain_split();

    // Reset during locked wait states
    HSEL = 1'b1; ahbm_HTRANS = 2'b10; ahbm_HADDR = 32'h44; ahbm_ahbs_HWRITE = 1'b0;
    ahbm_ahbs_HSIZE = 3'd2; arb_ahbs_HMASTER = 4'd1; arb_ahbs_HMASTLOCK = 1'b1;
    @(posedge HCLK);
    #1;
    HSEL = 1'b0; ahbm_HTRANS = 2'b00; arb_ahbs_HMASTLOCK = 1'b0;
    @(negedge HCLK);
    check("lock_wait_hready", {31'd0, ahbs_HREADY}, 32'd0);
    #1;
    async_reset();
    idle(6);
    xfer(32'h44, 1'b0, 3'd2, 32'd0, 4'd1, 1'b1);

    idle(2);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_split_slave.md
AHB_SPLIT_SLAVE -- requirements
Module: ahb_split_slave

Interface
REQ-001 Parameter SPLIT_DELAY, default 4: HCLK cycles from a SPLIT response to the HSPLIT pulse, and wait states used for a locked access to the split region.
REQ-002 Parameter MEM_WORDS, default 16: number of 32-bit storage words.
REQ-003 HCLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 HRESETn  input  1  reset; asynchronous assertion, active-low.
REQ-005 HSEL  input  1  slave select.
REQ-006 ahbm_HADDR  input  32  address.
REQ-007 ahbm_HTRANS  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 ahbm_ahbs_HWRITE  input  1  1 = write.
REQ-009 ahbm_ahbs_HSIZE  input  3  transfer size: 0 byte, 1 halfword, 2 word.
REQ-010 ahbm_HBURST  input  3  burst type; accepted and ignored.
REQ-011 ahbm_ahbs_HWDATA  input  32  write data, sampled in the data phase.
REQ-012 arb_ahbs_HMASTER  input  4  current master number.
REQ-013 arb_ahbs_HMASTLOCK  input  1  locked-transfer indication.
REQ-014 ahbs_HREADY  output  1  transfer done / slave ready.
REQ-015 ahbs_HRESP  output  2  response: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
REQ-016 ahbs_ahbm_HRDATA  output  32  read data.
REQ-017 ahbs_arb_HSPLIT  output  16  one-hot split-release request, one bit per master.

Function
REQ-018 The slave SHALL sample the address phase when ahbs_HREADY=1, HSEL=1 and HTRANS is NONSEQ or SEQ; all other phases (IDLE, BUSY, HSEL=0) SHALL get a zero-wait OKAY with no side effect.
REQ-019 Decode SHALL use HADDR[7:6]: 00 = RAM region, 01 = split region (aliases the same RAM), 1x = ERROR region.
REQ-020 RAM word index SHALL be HADDR[5:2] modulo MEM_WORDS.
REQ-021 Byte lanes SHALL be little-endian: a byte write updates only lane HADDR[1:0]; a halfword write updates lanes HADDR[1]*2 and HADDR[1]*2+1.
REQ-022 HSIZE>2, a halfword with HADDR[0]=1, or a word with HADDR[1:0]!=0 SHALL return ERROR and SHALL leave the RAM unchanged.
REQ-023 A RAM-region access SHALL complete with zero wait states and OKAY; read data SHALL be the full addressed word, valid in the data phase.
REQ-024 Every non-OKAY response SHALL take two cycles: first cycle HREADY=0 with HRESP set, second cycle HREADY=1 with the same HRESP.
REQ-025 A non-locked split-region access with no split pending SHALL return SPLIT, record HMASTER, and SHALL NOT perform the access.
REQ-026 SPLIT_DELAY cycles after the SPLIT response completes, ahbs_arb_HSPLIT[recorded master] SHALL pulse high for exactly one cycle.
REQ-027 After the pulse, the recorded master's next split-region access SHALL complete as a zero-wait OKAY access and SHALL clear the pending state.
REQ-028 A split-region access from any other master while a split is pending SHALL return RETRY with no side effect.
REQ-029 A split-region access from the recorded master before its pulse SHALL return RETRY.
REQ-030 A locked split-region access SHALL NOT be split; it SHALL insert SPLIT_DELAY wait states (HREADY=0, HRESP=OKAY) and then complete OKAY.
REQ-031 HRDATA SHALL hold its previous value outside read data phases.
REQ-032 The RAM SHALL be clocked through an integrated latch-based clock gate enabled only on write data phases; the gate SHALL be functionally invisible at the ports.

Reset
REQ-033 While HRESETn=0: ahbs_HREADY=1, ahbs_HRESP=00, ahbs_ahbm_HRDATA=0, ahbs_arb_HSPLIT=0, split pending cleared, all RAM words 0.
REQ-034 A reset during any wait or split sequence SHALL abort it with no HSPLIT pulse afterwards.

Verification
REQ-035 Word write 0xDEADBEEF to 0x04, then read 0x04 -> OKAY, zero wait, HRDATA=0xDEADBEEF.
REQ-036 Byte write 0xAA to 0x07 over a word holding 0x11223344 -> read returns 0xAA223344.
REQ-037 Master 3 reads 0x40 -> SPLIT over two cycles; HSPLIT=0x0008 for one cycle 4 cycles later; the retried read gets OKAY with the RAM word 0.
REQ-038 Split pending for master 3; master 5 accesses 0x44 -> RETRY; access to 0x80 -> ERROR; halfword at 0x01 -> ERROR.
REQ-039 Locked read of 0x40 -> HREADY low for 4 cycles, then OKAY; HSPLIT stays 0.
REQ-040 Reset asserted mid-split -> all outputs at reset values immediately; no HSPLIT pulse after release.
